// File: rtl/hazard_if.sv
// Control bundle between the pipeline registers and the hazard controller.
// The pipeline side uses the master modport and the controller uses the slave modport.
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] if_id_rs1;
    logic [REG_AW-1:0] if_id_rs2;
    logic              if_id_use_rs1;
    logic              if_id_use_rs2;
    logic              if_id_memwrite;
    logic [REG_AW-1:0] id_ex_rs1;
    logic [REG_AW-1:0] id_ex_rs2;
    logic [REG_AW-1:0] id_ex_rd;
    logic              id_ex_memread;
    logic              id_ex_regwrite;
    logic [REG_AW-1:0] ex_mem_rd;
    logic [REG_AW-1:0] ex_mem_rs2;
    logic              ex_mem_regwrite;
    logic              ex_mem_memread;
    logic              ex_mem_memwrite;
    logic [REG_AW-1:0] mem_wb_rd;
    logic              mem_wb_regwrite;
    logic              mem_wb_memread;
    logic              branch_taken;

    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic              forward_c;
    logic              stall_pc;
    logic              stall_if_id;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              stall_all;
    logic [CNT_W-1:0]  stall_cycles;

    modport slave (
        input  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2, if_id_memwrite,
        input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_memread, id_ex_regwrite,
        input  ex_mem_rd, ex_mem_rs2, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
        input  mem_wb_rd, mem_wb_regwrite, mem_wb_memread, branch_taken,
        output forward_a, forward_b, forward_c, stall_pc, stall_if_id,
        output flush_if_id, flush_id_ex, stall_all, stall_cycles
    );

    modport master (
        output if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2, if_id_memwrite,
        output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_memread, id_ex_regwrite,
        output ex_mem_rd, ex_mem_rs2, ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite,
        output mem_wb_rd, mem_wb_regwrite, mem_wb_memread, branch_taken,
        input  forward_a, forward_b, forward_c, stall_pc, stall_if_id,
        input  flush_if_id, flush_id_ex, stall_all, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage RV32 pipeline. It also provides a
// multi-cycle data-memory wait, branch flushes and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 0,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);
    typedef enum logic {IDLE, WAIT} state_t;

    function automatic logic hit(input logic [REG_AW-1:0] rd, input logic we,
                                 input logic [REG_AW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             fwd_c;
    logic             raw_load_use;
    logic             raw_no_fwd;
    logic             raw;
    logic             mem_stall;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             forward_c;
    logic             stall_pc;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             stall_all;
    logic [CNT_W-1:0] stall_cnt;

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    always_comb begin
        fwd_a = 2'b00;
        if (hit(hz.ex_mem_rd, hz.ex_mem_regwrite, hz.id_ex_rs1))
            fwd_a = 2'b10;
        else if (hit(hz.mem_wb_rd, hz.mem_wb_regwrite, hz.id_ex_rs1))
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (hit(hz.ex_mem_rd, hz.ex_mem_regwrite, hz.id_ex_rs2))
            fwd_b = 2'b10;
        else if (hit(hz.mem_wb_rd, hz.mem_wb_regwrite, hz.id_ex_rs2))
            fwd_b = 2'b01;
    end

    assign fwd_c = hz.mem_wb_memread && hz.ex_mem_memwrite
                && hit(hz.mem_wb_rd, 1'b1, hz.ex_mem_rs2);

    // A store's data source is covered by the MEM-stage path, so it never load-use stalls.
    assign raw_load_use = hz.id_ex_memread && (
                            (hit(hz.id_ex_rd, 1'b1, hz.if_id_rs1) && hz.if_id_use_rs1) ||
                            (hit(hz.id_ex_rd, 1'b1, hz.if_id_rs2) && hz.if_id_use_rs2
                             && !hz.if_id_memwrite));

    assign raw_no_fwd = (hz.if_id_use_rs1 &&
                           (hit(hz.id_ex_rd, hz.id_ex_regwrite, hz.if_id_rs1) ||
                            hit(hz.ex_mem_rd, hz.ex_mem_regwrite, hz.if_id_rs1))) ||
                        (hz.if_id_use_rs2 &&
                           (hit(hz.id_ex_rd, hz.id_ex_regwrite, hz.if_id_rs2) ||
                            hit(hz.ex_mem_rd, hz.ex_mem_regwrite, hz.if_id_rs2)));

    assign raw = (FWD_EN != 0) ? raw_load_use : raw_no_fwd;

    generate
        if (MEM_LAT > 0) begin : g_mem_fsm
            state_t     state_q;
            state_t     state_d;
            logic [3:0] wcnt_q;
            logic [3:0] wcnt_d;
            logic       mem_acc;

            assign mem_acc = hz.ex_mem_memread | hz.ex_mem_memwrite;

            // NOTE: state registers use non-blocking assignments so every flop samples
            // pre-edge values regardless of process ordering.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= IDLE;
                    wcnt_q  <= '0;
                end else begin
                    state_q <= state_d;
                    wcnt_q  <= wcnt_d;
                end
            end

            // NOTE: every output of this block gets a default first so no path infers a latch.
            always_comb begin
                state_d   = state_q;
                wcnt_d    = wcnt_q;
                mem_stall = 1'b0;
                unique case (state_q)
                    IDLE: begin
                        if (mem_acc) begin
                            mem_stall = 1'b1;
                            state_d   = WAIT;
                            wcnt_d    = 4'(MEM_LAT - 1);
                        end
                    end
                    WAIT: begin
                        if (wcnt_q != '0) begin
                            mem_stall = 1'b1;
                            wcnt_d    = wcnt_q - 4'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else begin : g_no_mem_fsm
            assign mem_stall = 1'b0;
        end
    endgenerate

    // A frozen pipeline keeps the taken branch in ID/EX, so its flush waits for release.
    always_comb begin
        forward_a   = 2'b00;
        forward_b   = 2'b00;
        forward_c   = 1'b0;
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        stall_all   = 1'b0;
        if (!rst) begin
            if (FWD_EN != 0) begin
                forward_a = fwd_a;
                forward_b = fwd_b;
                forward_c = fwd_c;
            end
            if (mem_stall) begin
                stall_all = 1'b1;
            end else if (hz.branch_taken) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (raw) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if ((stall_pc || stall_all) && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign hz.forward_a    = forward_a;
    assign hz.forward_b    = forward_b;
    assign hz.forward_c    = forward_c;
    assign hz.stall_pc     = stall_pc;
    assign hz.stall_if_id  = stall_if_id;
    assign hz.flush_if_id  = flush_if_id;
    assign hz.flush_id_ex  = flush_id_ex;
    assign hz.stall_all    = stall_all;
    assign hz.stall_cycles = stall_cnt;
endmodule
